branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor for the five-stage RISC-V pipeline core. It is looked up combinationally by the fetch stage with the current PC and returns a taken/not-taken prediction plus next-fetch target. It is trained one cycle-boundary later by the resolved outcome that the execute stage reports. Internally it is a direct-mapped, tagged table of 2-bit saturating counters with a branch target buffer (BTB) field per entry.

## Interface
- `ENTRIES`, default 64: number of table entries; must be a power of two, at least 4.
- `INDEX_W`, default $clog2(ENTRIES): index width (derived; do not override).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `PCF`  in  32  fetch-stage PC being looked up.
- `Predict_branchF`  out  1  prediction: taken.
- `PredTargetF`  out  32  predicted next PC: BTB target if taken, else PCF+4.
- `StateUpdateEnable`  in  1  execute stage holds a branch or jump this cycle.
- `PCE`  in  32  PC of the resolving instruction.
- `Eval_branch`  in  1  actual outcome: 1 = taken (jumps always 1).
- `ResolvedTargetE`  in  32  actual taken target (PC+imm or jalr result).
- `Prediction_Correct`  in  1  execute-side compare of prediction vs outcome; used only by the performance counters.
- `BranchCountO`  out  32  resolved branches/jumps counted.
- `MispredictCountO`  out  32  mispredictions counted.

## Operation
- Entry fields: `valid` (1), `tag` (32-INDEX_W-2), `ctr` (2), `target` (32).
- Index is PC[INDEX_W+1:2]. Tag is PC[31:INDEX_W+2]. PC[1:0] is ignored.
- Counter states: SNT=00, WNT=01, WT=10, ST=11.
- Lookup (combinational):
  - hit = valid & tag match.
  - Predict_branchF = hit & ctr[1].
  - PredTargetF = Predict_branchF ? target : PCF+4. The add is 32-bit and wraps mod 2^32.
- Update, at the clock edge when StateUpdateEnable=1, at index/tag of PCE:
  - Hit, taken: ctr saturating +1 (ST stays ST); target <= ResolvedTargetE.
  - Hit, not taken: ctr saturating −1 (SNT stays SNT); target unchanged.
  - Miss, taken: allocate and overwrite the entry. valid=1, tag=PCE tag, ctr=WT, target=ResolvedTargetE.
  - Miss, not taken: no change (no allocation).
- When StateUpdateEnable=0, the table does not change.
- Unknown or X on the update inputs is not expected while StateUpdateEnable=0 and is ignored.

## Timing
- Lookup latency is 0 cycles; it is purely combinational from PCF and the table state.
- Update takes effect at the same rising edge it is presented on. A lookup in the following cycle sees the new state.
- Simultaneous lookup and update to the same index in one cycle: the lookup returns the pre-update contents. There is no write-to-read bypass.
- Reset (async assert, any time, including mid-update): every entry gets valid=0, ctr=WNT, target=0. Reset assertion is asynchronous; deassertion is synchronized by the core's reset logic.
- Output values in reset: Predict_branchF=0, PredTargetF=PCF+4, BranchCountO=0, MispredictCountO=0.
- An update in progress during reset is discarded.

## Configuration
- `BP_PERF_CNT_EN`
  - Defined:
    - BranchCountO increments at each edge with StateUpdateEnable=1.
    - MispredictCountO increments when StateUpdateEnable=1 & !Prediction_Correct.
    - Both are 32-bit, wrap 0xFFFFFFFF→0, and reset to 0.
  - Undefined: no counter flops exist, both outputs are tied to 0, and Prediction_Correct is unused.

## Structure
- Package `bp_pkg`:
  - counter state localparams SNT/WNT/WT/ST;
  - reset counter value (WNT);
  - allocate counter value (WT).
- Sub-module `bp_sat_counter`: 2-bit saturating up/down next-state function. Inputs are ctr and taken; output is next ctr. Instantiated once, on the update path.
- Table storage is flop arrays (no SRAM macro), so that the asynchronous reset clears it.

## Test plan
- Reset, then PCF=0x100 → Predict_branchF=0, PredTargetF=0x104; with BP_PERF_CNT_EN, both counters read 0.
- First allocation:
  - Update PCE=0x100, taken, target 0x80.
  - Next cycle PCF=0x100 → Predict_branchF=1, PredTargetF=0x80 (entry is WT).
- Counter walk on PCE=0x200:
  - Updates taken, taken, not-taken, not-taken, not-taken → ctr sequence WT, ST, WT, WNT, SNT; prediction 1,1,1,0,0.
  - Four further not-taken updates hold SNT.
- Aliasing with ENTRIES=64:
  - Allocate PCE=0x100 taken → 0x80; PCF=0x200 (same index, different tag) → not predicted.
  - Update 0x200 taken → 0x300; PCF=0x100 → not predicted, PCF=0x200 → predicts 0x300.
- Same-cycle read/update:
  - PCF=0x100 while allocating 0x100 in the same cycle → that cycle Predict_branchF=0; next cycle 1.
- Async reset mid-stream and counters:
  - Assert rst_n low between edges after 3 updates (1 mispredicted) → prior lookup of 0x100 drops to 0 immediately.
  - Before the reset, with BP_PERF_CNT_EN, counters read 3 and 1.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared constants for the branch predictor: 2-bit counter encodings and
// the counter values used at reset and when a new entry is allocated.
package bp_pkg;

    localparam logic [1:0] CTR_SNT   = 2'b00;
    localparam logic [1:0] CTR_WNT   = 2'b01;
    localparam logic [1:0] CTR_WT    = 2'b10;
    localparam logic [1:0] CTR_ST    = 2'b11;

    localparam logic [1:0] CTR_RESET = CTR_WNT;
    localparam logic [1:0] CTR_ALLOC = CTR_WT;

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating up/down counter next-state function used on the
// predictor's training path.
module bp_sat_counter
    import bp_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    // Step toward taken/not-taken, holding at the end states
    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != CTR_ST) begin
                ctr_o = ctr_i + 2'd1;
            end else begin
                ctr_o = CTR_ST;
            end
        end else begin
            if (ctr_i != CTR_SNT) begin
                ctr_o = ctr_i - 2'd1;
            end else begin
                ctr_o = CTR_SNT;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped, tagged table of 2-bit counters with a BTB target per entry.
// Defining BP_PERF_CNT_EN adds branch / misprediction performance counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int INDEX_W = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PCF,
    output logic        Predict_branchF,
    output logic [31:0] PredTargetF,
    input  logic        StateUpdateEnable,
    input  logic [31:0] PCE,
    input  logic        Eval_branch,
    input  logic [31:0] ResolvedTargetE,
    input  logic        Prediction_Correct,
    output logic [31:0] BranchCountO,
    output logic [31:0] MispredictCountO
);

    localparam int TAG_W = 32 - INDEX_W - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];

    logic [INDEX_W-1:0] lk_idx_s;
    logic [TAG_W-1:0]   lk_tag_s;
    logic               lk_hit_s;
    logic               pred_s;

    logic [INDEX_W-1:0] up_idx_s;
    logic [TAG_W-1:0]   up_tag_s;
    logic               up_hit_s;
    logic [1:0]         up_ctr_cur_s;
    logic [1:0]         up_ctr_sat_s;
    logic               up_we_s;
    logic [1:0]         up_ctr_d;
    logic [31:0]        up_target_d;

    logic               unused_s;

    // Fetch-side lookup: reads table state only, so an update in the same
    // cycle is not visible until the next one
    always_comb begin
        lk_idx_s = PCF[INDEX_W+1:2];
        lk_tag_s = PCF[31:INDEX_W+2];
        lk_hit_s = valid_q[lk_idx_s] && (tag_q[lk_idx_s] == lk_tag_s);
        pred_s   = lk_hit_s && ctr_q[lk_idx_s][1];
        if (pred_s) begin
            PredTargetF = target_q[lk_idx_s];
        end else begin
            PredTargetF = PCF + 32'd4;
        end
    end

    assign Predict_branchF = pred_s;
    assign up_ctr_cur_s    = ctr_q[up_idx_s];

    bp_sat_counter u_sat_counter (
        .ctr_i   (up_ctr_cur_s),
        .taken_i (Eval_branch),
        .ctr_o   (up_ctr_sat_s)
    );

    // Training decision: train a hit, allocate on a taken miss, else leave alone
    always_comb begin
        up_idx_s    = PCE[INDEX_W+1:2];
        up_tag_s    = PCE[31:INDEX_W+2];
        up_hit_s    = valid_q[up_idx_s] && (tag_q[up_idx_s] == up_tag_s);
        up_we_s     = 1'b0;
        up_ctr_d    = up_ctr_cur_s;
        up_target_d = target_q[up_idx_s];
        if (StateUpdateEnable) begin
            if (up_hit_s) begin
                up_we_s  = 1'b1;
                up_ctr_d = up_ctr_sat_s;
                if (Eval_branch) begin
                    up_target_d = ResolvedTargetE;
                end else begin
                    up_target_d = target_q[up_idx_s];
                end
            end else if (Eval_branch) begin
                up_we_s     = 1'b1;
                up_ctr_d    = CTR_ALLOC;
                up_target_d = ResolvedTargetE;
            end else begin
                up_we_s = 1'b0;
            end
        end else begin
            up_we_s = 1'b0;
        end
    end

    // Table storage; async reset clears every entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= {TAG_W{1'b0}};
                ctr_q[i]    <= CTR_RESET;
                target_q[i] <= 32'd0;
            end
        end else if (up_we_s) begin
            valid_q[up_idx_s]  <= 1'b1;
            tag_q[up_idx_s]    <= up_tag_s;
            ctr_q[up_idx_s]    <= up_ctr_d;
            target_q[up_idx_s] <= up_target_d;
        end else begin
            valid_q <= valid_q;
        end
    end

`ifdef BP_PERF_CNT_EN
    logic [31:0] branch_cnt_q;
    logic [31:0] branch_cnt_d;
    logic [31:0] mispredict_cnt_q;
    logic [31:0] mispredict_cnt_d;

    // Counter next-state; both wrap naturally at 32 bits
    always_comb begin
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (StateUpdateEnable) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
            if (!Prediction_Correct) begin
                mispredict_cnt_d = mispredict_cnt_q + 32'd1;
            end else begin
                mispredict_cnt_d = mispredict_cnt_q;
            end
        end else begin
            branch_cnt_d = branch_cnt_q;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q     <= 32'd0;
            mispredict_cnt_q <= 32'd0;
        end else begin
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign BranchCountO     = branch_cnt_q;
    assign MispredictCountO = mispredict_cnt_q;
    assign unused_s         = ^PCE[1:0];
`else
    assign BranchCountO     = 32'd0;
    assign MispredictCountO = 32'd0;
    assign unused_s         = ^{Prediction_Correct, PCE[1:0]};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by
// random traffic compared against an array-based behavioural model.
module tb_branch_predictor;

    localparam int ENTRIES = 64;

    logic        clk;
    logic        rst_n;
    logic [31:0] PCF;
    logic        Predict_branchF;
    logic [31:0] PredTargetF;
    logic        StateUpdateEnable;
    logic [31:0] PCE;
    logic        Eval_branch;
    logic [31:0] ResolvedTargetE;
    logic        Prediction_Correct;
    logic [31:0] BranchCountO;
    logic [31:0] MispredictCountO;

    int total;
    int bad;

    bit          m_valid [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    int          m_ctr   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_br;
    int          m_mis;

    branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .PCF                (PCF),
        .Predict_branchF    (Predict_branchF),
        .PredTargetF        (PredTargetF),
        .StateUpdateEnable  (StateUpdateEnable),
        .PCE                (PCE),
        .Eval_branch        (Eval_branch),
        .ResolvedTargetE    (ResolvedTargetE),
        .Prediction_Correct (Prediction_Correct),
        .BranchCountO       (BranchCountO),
        .MispredictCountO   (MispredictCountO)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int midx(input logic [31:0] pc);
        return int'((pc / 32'd4) % ENTRIES);
    endfunction

    function automatic logic [31:0] mtag(input logic [31:0] pc);
        return pc / (32'd4 * ENTRIES);
    endfunction

    function automatic bit mhit(input logic [31:0] pc);
        return m_valid[midx(pc)] && (m_tag[midx(pc)] == mtag(pc));
    endfunction

    function automatic bit mpred(input logic [31:0] pc);
        return mhit(pc) && (m_ctr[midx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] mtarget(input logic [31:0] pc);
        if (mpred(pc)) return m_tgt[midx(pc)];
        return pc + 32'd4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 32'd0;
            m_ctr[i]   = 1;
            m_tgt[i]   = 32'd0;
        end
        m_br  = 0;
        m_mis = 0;
    endtask

    task automatic model_update(input logic [31:0] pc, input bit taken, input logic [31:0] tgt, input bit pcorr);
        int i;
        i = midx(pc);
        m_br++;
        if (!pcorr) m_mis++;
        if (mhit(pc)) begin
            if (taken) begin
                m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                m_tgt[i] = tgt;
            end else begin
                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
        end else if (taken) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = mtag(pc);
            m_ctr[i]   = 2;
            m_tgt[i]   = tgt;
        end
    endtask

    task automatic check_lookup(input string tag);
        check_val({tag, "_pred"}, {31'd0, Predict_branchF}, {31'd0, mpred(PCF)});
        check_val({tag, "_tgt"}, PredTargetF, mtarget(PCF));
    endtask

    task automatic check_counts(input string tag);
`ifdef BP_PERF_CNT_EN
        check_val({tag, "_brcnt"}, BranchCountO, m_br);
        check_val({tag, "_miscnt"}, MispredictCountO, m_mis);
`else
        check_val({tag, "_brcnt"}, BranchCountO, 32'd0);
        check_val({tag, "_miscnt"}, MispredictCountO, 32'd0);
`endif
    endtask

    // Called just after a rising edge: drive, check lookup mid-cycle, clock, check counters
    task automatic cycle(input string tag, input logic [31:0] pcf, input bit en, input logic [31:0] pce,
                         input bit taken, input logic [31:0] tgt, input bit pcorr);
        PCF                = pcf;
        StateUpdateEnable  = en;
        PCE                = pce;
        Eval_branch        = taken;
        ResolvedTargetE    = tgt;
        Prediction_Correct = pcorr;
        #3;
        check_lookup(tag);
        @(posedge clk);
        if (en) model_update(pce, taken, tgt, pcorr);
        #1;
        check_counts(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        StateUpdateEnable = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_pc();
        if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
        return 32'($urandom_range(0, 3) * ENTRIES * 4 + $urandom_range(0, 7) * 4 + $urandom_range(0, 3));
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        PCF = 32'h100;
        StateUpdateEnable = 1'b0;
        PCE = 32'd0;
        Eval_branch = 1'b0;
        ResolvedTargetE = 32'd0;
        Prediction_Correct = 1'b1;
        model_reset();
        #2;
        check_val("rst_pred", {31'd0, Predict_branchF}, 32'd0);
        check_val("rst_tgt", PredTargetF, 32'h104);
        check_counts("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First allocation
        cycle("alloc", 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0);
        cycle("alloc_look", 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check_val("alloc_pred_const", {31'd0, Predict_branchF}, 32'd1);
        check_val("alloc_tgt_const", PredTargetF, 32'h80);

        // Counter walk on 0x200: T,T,N,N,N then four more N
        for (int k = 0; k < 9; k++) begin
            cycle("walk", 32'h200, 1'b1, 32'h200, (k < 2), 32'h240, 1'b1);
            cycle("walk_look", 32'h200, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        end
        check_val("walk_snt_pred", {31'd0, Predict_branchF}, 32'd0);

        // Aliasing: 0x100 and 0x200 share index 0
        cycle("alias_a", 32'h200, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1);
        cycle("alias_b", 32'h200, 1'b1, 32'h200, 1'b1, 32'h300, 1'b1);
        cycle("alias_c", 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        cycle("alias_d", 32'h200, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check_val("alias_tgt_const", PredTargetF, 32'h300);

        // Same-cycle lookup and allocation: no bypass
        cycle("same_cyc", 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1);
        cycle("same_next", 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

        // PC+4 wraps at the top of the address space
        cycle("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check_val("wrap_const", PredTargetF, 32'h0);

        // Async reset mid-stream after three updates, one mispredicted
        do_reset();
        cycle("ar1", 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1);
        cycle("ar2", 32'h100, 1'b1, 32'h300, 1'b1, 32'h500, 1'b0);
        cycle("ar3", 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1);
`ifdef BP_PERF_CNT_EN
        check_val("ar_brcnt_const", BranchCountO, 32'd3);
        check_val("ar_miscnt_const", MispredictCountO, 32'd1);
`endif
        PCF = 32'h100;
        StateUpdateEnable = 1'b1;
        PCE = 32'h400;
        Eval_branch = 1'b1;
        ResolvedTargetE = 32'h900;
        #1;
        check_val("ar_pre_pred", {31'd0, Predict_branchF}, 32'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_val("ar_drop_pred", {31'd0, Predict_branchF}, 32'd0);
        check_val("ar_drop_tgt", PredTargetF, 32'h104);
        check_counts("ar_drop");
        @(posedge clk);
        @(negedge clk);
        StateUpdateEnable = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle("ar_discard", 32'h400, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            logic [31:0] pce_r;
            logic [31:0] pcf_r;
            pce_r = rand_pc();
            pcf_r = ($urandom_range(0, 3) == 0) ? pce_r : rand_pc();
            cycle("rnd", pcf_r, ($urandom_range(0, 3) != 0), pce_r, $urandom_range(0, 1) == 1,
                  $urandom(), $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
